// File: rtl/poly_alu_seq.sv
// poly_alu_seq: streams one polynomial operation through the POLY_ALU datapath.
// An accepted start latches the op config and issues cfg_len coefficient reads
// from src memory. Enables to the ALU follow the reads by RD_LAT cycles, and
// each poly_valid result is written to dst memory at the next address.
//
// Ports:
//   poly_clk, poly_rst        clock, asynchronous active-high reset
//   cfg_start                 start pulse, only honoured in IDLE
//   cfg_mode/decompose/compress/duv_mode
//                             ALU config, latched on accepted start
//   cfg_src_base, cfg_dst_base first read / write address
//   cfg_len                   coefficient count, 0..2^AW
//   rd_en, rd_addr            src RAM read strobe and address
//   alu_enable, alu_mode, alu_decompose, alu_compress, alu_duv_mode
//                             ALU enable and registered config
//   alu_valid                 ALU result strobe
//   wr_en, wr_addr            dst RAM write strobe and address
//   busy, done, err           status: busy in ISSUE/DRAIN, done pulse,
//                             sticky unexpected-valid flag
module poly_alu_seq #(
    parameter int AW      = 8,
    parameter int RD_LAT  = 1,
    parameter int ALU_LAT = 5
) (
    input  logic          poly_clk,
    input  logic          poly_rst,
    input  logic          cfg_start,
    input  logic [9:0]    cfg_mode,
    input  logic [1:0]    cfg_decompose,
    input  logic [1:0]    cfg_compress,
    input  logic [1:0]    cfg_duv_mode,
    input  logic [AW-1:0] cfg_src_base,
    input  logic [AW-1:0] cfg_dst_base,
    input  logic [AW:0]   cfg_len,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          alu_enable,
    output logic [9:0]    alu_mode,
    output logic [1:0]    alu_decompose,
    output logic [1:0]    alu_compress,
    output logic [1:0]    alu_duv_mode,
    input  logic          alu_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("poly_alu_seq: RD_LAT must be at least 1");
    end
    if (ALU_LAT < 1) begin : g_bad_alu_lat
        $error("poly_alu_seq: ALU_LAT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [AW:0]       len_r;
    logic [AW:0]       rd_cnt;
    logic [AW:0]       wr_cnt;
    logic [AW-1:0]     src_base_r;
    logic [AW-1:0]     dst_base_r;
    logic [RD_LAT-1:0] en_sr;
    logic              start_ok;
    logic              active;

    always_comb begin
        start_ok  = (state == IDLE) && cfg_start;
        active    = (state == ISSUE) || (state == DRAIN);
        rd_en     = (state == ISSUE);
        busy      = active;
        done      = (state == DONE);
        // The count guard keeps a stray valid from writing past the buffer
        // in the cycle the FSM is already leaving DRAIN.
        wr_en     = active && alu_valid && (wr_cnt != len_r);
        rd_addr   = src_base_r + rd_cnt[AW-1:0];
        wr_addr   = dst_base_r + wr_cnt[AW-1:0];
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (rd_cnt == len_r - 1'b1) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Look ahead at the write happening this cycle so done
                // follows the last write with no idle gap.
                if ((wr_cnt == len_r) || (wr_en && (wr_cnt + 1'b1 == len_r))) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge poly_clk or posedge poly_rst) begin
        if (poly_rst) begin
            state         <= IDLE;
            len_r         <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            src_base_r    <= '0;
            dst_base_r    <= '0;
            alu_mode      <= '0;
            alu_decompose <= '0;
            alu_compress  <= '0;
            alu_duv_mode  <= '0;
            err           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                len_r         <= cfg_len;
                src_base_r    <= cfg_src_base;
                dst_base_r    <= cfg_dst_base;
                alu_mode      <= cfg_mode;
                alu_decompose <= cfg_decompose;
                alu_compress  <= cfg_compress;
                alu_duv_mode  <= cfg_duv_mode;
                rd_cnt        <= '0;
                wr_cnt        <= '0;
            end else begin
                if (rd_en) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (wr_en) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            // A valid outside an operation has nowhere to go; flag it even
            // if it coincides with a start.
            if (!active && alu_valid) begin
                err <= 1'b1;
            end else if (start_ok) begin
                err <= 1'b0;
            end
        end
    end

    if (RD_LAT > 1) begin : g_sr_multi
        always_ff @(posedge poly_clk or posedge poly_rst) begin
            if (poly_rst) begin
                en_sr <= '0;
            end else begin
                en_sr <= {en_sr[RD_LAT-2:0], rd_en};
            end
        end
    end else begin : g_sr_one
        always_ff @(posedge poly_clk or posedge poly_rst) begin
            if (poly_rst) begin
                en_sr <= '0;
            end else begin
                en_sr <= rd_en;
            end
        end
    end

    assign alu_enable = en_sr[RD_LAT-1];

endmodule

// File: tb/tb_poly_alu_seq.sv
// Bench for poly_alu_seq: a table of operations run through a scoreboard of
// expected read/write addresses, plus hand sequences for unexpected valids
// and reset in the middle of an operation. A 5-stage ALU model turns
// alu_enable into alu_valid.
module tb_poly_alu_seq;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [9:0]    cfg_mode;
    logic [1:0]    cfg_decompose;
    logic [1:0]    cfg_compress;
    logic [1:0]    cfg_duv_mode;
    logic [AW-1:0] cfg_src_base;
    logic [AW-1:0] cfg_dst_base;
    logic [AW:0]   cfg_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          alu_enable;
    logic [9:0]    alu_mode;
    logic [1:0]    alu_decompose;
    logic [1:0]    alu_compress;
    logic [1:0]    alu_duv_mode;
    logic          alu_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          err;

    logic [4:0]    pipe = '0;
    logic          force_valid;

    int checks = 0;
    int errors = 0;

    poly_alu_seq #(
        .AW     (AW),
        .RD_LAT (1),
        .ALU_LAT(5)
    ) dut (
        .poly_clk     (clk),
        .poly_rst     (rst),
        .cfg_start    (cfg_start),
        .cfg_mode     (cfg_mode),
        .cfg_decompose(cfg_decompose),
        .cfg_compress (cfg_compress),
        .cfg_duv_mode (cfg_duv_mode),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_len      (cfg_len),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .alu_enable   (alu_enable),
        .alu_mode     (alu_mode),
        .alu_decompose(alu_decompose),
        .alu_compress (alu_compress),
        .alu_duv_mode (alu_duv_mode),
        .alu_valid    (alu_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // ALU model: the real ALU has no reset link to the sequencer, so pending
    // results keep emerging after a sequencer reset.
    always @(posedge clk) pipe <= {pipe[3:0], alu_enable};
    assign alu_valid = pipe[4] | force_valid;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        logic [9:0] mode;
        logic [1:0] dec;
        logic [1:0] comp;
        logic [1:0] duv;
        int         restart_at;
        int         exp_done;
        int         exp_busy;
    } vec_t;

    vec_t       tv [8];
    logic [7:0] rq [$];
    logic [7:0] wq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input vec_t v);
        int cyc, n_rd, n_en, n_wr, n_busy, f_rd, f_en, f_wr, done_cyc;
        logic [7:0] a;
        @(negedge clk);
        cfg_src_base  = v.src;
        cfg_dst_base  = v.dst;
        cfg_len       = v.len;
        cfg_mode      = v.mode;
        cfg_decompose = v.dec;
        cfg_compress  = v.comp;
        cfg_duv_mode  = v.duv;
        cfg_start     = 1'b1;
        rq.delete();
        wq.delete();
        for (int i = 0; i < int'(v.len); i++) begin
            rq.push_back(v.src + 8'(i));
            wq.push_back(v.dst + 8'(i));
        end
        n_rd = 0; n_en = 0; n_wr = 0; n_busy = 0;
        f_rd = -1; f_en = -1; f_wr = -1; done_cyc = -1;
        cyc = 0;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            cfg_start = 1'b0;
            if (cyc == v.restart_at) begin
                cfg_start     = 1'b1;
                cfg_mode      = 10'h3FF;
                cfg_len       = 9'd2;
                cfg_src_base  = 8'hAA;
                cfg_dst_base  = 8'hBB;
                cfg_decompose = ~v.dec;
                cfg_compress  = ~v.comp;
                cfg_duv_mode  = ~v.duv;
            end
            #1;
            if (cyc == 1) chk("err_cleared_by_start", err, 0);
            if (rd_en) begin
                n_rd++;
                if (f_rd < 0) f_rd = cyc;
                if (rq.size() == 0) chk("rd_unexpected", rd_en, 0);
                else begin
                    a = rq.pop_front();
                    chk("rd_addr", rd_addr, a);
                end
            end
            if (wr_en) begin
                n_wr++;
                if (f_wr < 0) f_wr = cyc;
                if (wq.size() == 0) chk("wr_unexpected", wr_en, 0);
                else begin
                    a = wq.pop_front();
                    chk("wr_addr", wr_addr, a);
                end
            end
            if (alu_enable) begin
                n_en++;
                if (f_en < 0) f_en = cyc;
            end
            if (busy) n_busy++;
            if (done) done_cyc = cyc;
        end
        chk("done_cycle", done_cyc, v.exp_done);
        chk("busy_cycles", n_busy, v.exp_busy);
        chk("rd_count", n_rd, int'(v.len));
        chk("en_count", n_en, int'(v.len));
        chk("wr_count", n_wr, int'(v.len));
        chk("rd_queue_left", rq.size(), 0);
        chk("wr_queue_left", wq.size(), 0);
        chk("alu_mode", alu_mode, v.mode);
        chk("alu_decompose", alu_decompose, v.dec);
        chk("alu_compress", alu_compress, v.comp);
        chk("alu_duv_mode", alu_duv_mode, v.duv);
        if (v.len != 0) begin
            chk("first_rd_cycle", f_rd, 1);
            chk("first_en_cycle", f_en, 2);
            chk("first_wr_cycle", f_wr, 7);
        end
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wr;
        int cyc;
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_mode      = '0;
        cfg_decompose = '0;
        cfg_compress  = '0;
        cfg_duv_mode  = '0;
        cfg_src_base  = '0;
        cfg_dst_base  = '0;
        cfg_len       = '0;
        force_valid   = 1'b0;

        tv[0] = '{8'h00, 8'h80, 9'd4,   10'h155, 2'd1, 2'd2, 2'd3, 0, 11,  10};
        tv[1] = '{8'h10, 8'h20, 9'd0,   10'h0AA, 2'd2, 2'd1, 2'd0, 0, 1,   0};
        tv[2] = '{8'hFE, 8'h00, 9'd4,   10'h201, 2'd3, 2'd0, 2'd1, 0, 11,  10};
        tv[3] = '{8'h40, 8'hFF, 9'd3,   10'h0F0, 2'd0, 2'd3, 2'd2, 0, 10,  9};
        tv[4] = '{8'h00, 8'h00, 9'd256, 10'h3C3, 2'd1, 2'd1, 2'd1, 0, 263, 262};
        tv[5] = '{8'h7F, 8'h30, 9'd1,   10'h001, 2'd2, 2'd2, 2'd2, 0, 8,   7};
        tv[6] = '{8'h50, 8'h60, 9'd8,   10'h12A, 2'd1, 2'd0, 2'd2, 3, 15,  14};
        tv[7] = '{8'h33, 8'h44, 9'd2,   10'h2D2, 2'd3, 2'd3, 2'd0, 9, 9,   8};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_alu_enable", alu_enable, 0);
        chk("rst_alu_mode", alu_mode, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) run_op(tv[k]);

        // Valid with no operation in flight.
        @(negedge clk);
        force_valid = 1'b1;
        #1;
        chk("idle_valid_wr_en", wr_en, 0);
        @(negedge clk);
        #1;
        chk("idle_valid_wr_en2", wr_en, 0);
        chk("idle_valid_err", err, 1);
        @(negedge clk);
        force_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("err_sticky", err, 1);
        run_op(tv[0]);

        // Reset while two results are still pending.
        @(negedge clk);
        cfg_src_base = 8'h00;
        cfg_dst_base = 8'h80;
        cfg_len      = 9'd4;
        cfg_mode     = 10'h2B5;
        cfg_start    = 1'b1;
        n_wr = 0;
        cyc  = 0;
        while (n_wr < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            cfg_start = 1'b0;
            #1;
            if (wr_en) begin
                chk("pre_rst_wr_addr", wr_addr, 8'h80 + 8'(n_wr));
                n_wr++;
            end
        end
        chk("pre_rst_wr_cycle", cyc, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_alu_enable", alu_enable, 0);
        chk("mid_rst_alu_mode", alu_mode, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_en", wr_en, 0);
        @(negedge clk);
        #1;
        chk("post_rst_err", err, 1);
        chk("post_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        run_op(tv[5]);
        run_op(tv[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
